// File: rtl/phase_sequencer.sv
// Instruction-cycle phase/step sequencer driving the ISR decoder.
// Walks IF/FF/TF/EX/IT with configurable step counts, ACK waits, operand skipping and retirement count.
module phase_sequencer #(
  parameter int unsigned IF_N     = 2,
  parameter int unsigned FF_N     = 3,
  parameter int unsigned TF_N     = 2,
  parameter int unsigned EX_N     = 2,
  parameter int unsigned IT_N     = 3,
  parameter bit          ACK_WAIT = 1'b1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TOTAL    = IF_N + FF_N + TF_N + EX_N + IT_N
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             ITA,
  input  logic             ACK,
  input  logic             FROM_D,
  input  logic             TO_D,
  output logic [TOTAL-1:0] state_oh,
  output logic [2:0]       phase,
  output logic [2:0]       step,
  output logic             stall,
  output logic             instr_done,
  output logic [CNT_W-1:0] inst_count
);

  if (IF_N < 1 || IF_N > 8 || FF_N < 1 || FF_N > 8 || TF_N < 1 || TF_N > 8 ||
      EX_N < 1 || EX_N > 8 || IT_N < 1 || IT_N > 8) begin : g_bad_steps
    $error("phase_sequencer: every step count must be in 1..8");
  end
  if (TOTAL != IF_N + FF_N + TF_N + EX_N + IT_N) begin : g_bad_total
    $error("phase_sequencer: TOTAL must equal the sum of the step counts");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("phase_sequencer: CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    PH_IF = 3'd0,
    PH_FF = 3'd1,
    PH_TF = 3'd2,
    PH_EX = 3'd3,
    PH_IT = 3'd4
  } phase_t;

  phase_t     phase_q, phase_d;
  logic [2:0] step_q, step_d;
  logic [2:0] last_idx;
  logic       last_step;
  logic       ack_step;
  logic       retire_d;

  // Bit position of (phase, step) inside the LSB-first packed one-hot vector.
  function automatic logic [TOTAL-1:0] onehot(phase_t p, logic [2:0] s);
    int unsigned base;
    case (p)
      PH_FF:   base = IF_N;
      PH_TF:   base = IF_N + FF_N;
      PH_EX:   base = IF_N + FF_N + TF_N;
      PH_IT:   base = IF_N + FF_N + TF_N + EX_N;
      default: base = 0;
    endcase
    return TOTAL'(1) << (base + 32'(s));
  endfunction

  always_comb begin
    case (phase_q)
      PH_IF:   last_idx = 3'(IF_N - 1);
      PH_FF:   last_idx = 3'(FF_N - 1);
      PH_TF:   last_idx = 3'(TF_N - 1);
      PH_EX:   last_idx = 3'(EX_N - 1);
      PH_IT:   last_idx = 3'(IT_N - 1);
      default: last_idx = '0;
    endcase
  end

  assign last_step = (step_q == last_idx);
  assign ack_step  = ACK_WAIT && last_step && (phase_q != PH_EX);
  assign stall     = run && ack_step && !ACK;

  always_comb begin
    phase_d  = phase_q;
    step_d   = step_q;
    retire_d = 1'b0;
    if (run) begin
      if (!last_step) begin
        step_d = step_q + 3'd1;
      end else if (!(ack_step && !ACK)) begin
        step_d = '0;
        case (phase_q)
          PH_IF:   phase_d = !FROM_D ? PH_FF : (!TO_D ? PH_TF : PH_EX);
          PH_FF:   phase_d = !TO_D ? PH_TF : PH_EX;
          PH_TF:   phase_d = PH_EX;
          PH_EX: begin
            if (ITA) begin
              phase_d = PH_IT;
            end else begin
              phase_d  = PH_IF;
              retire_d = 1'b1;
            end
          end
          default: begin
            phase_d  = PH_IF;
            retire_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= PH_IF;
      step_q     <= '0;
      state_oh   <= TOTAL'(1);
      instr_done <= 1'b0;
      inst_count <= '0;
    end else begin
      phase_q    <= phase_d;
      step_q     <= step_d;
      state_oh   <= onehot(phase_d, step_d);
      instr_done <= retire_d;
      if (retire_d) begin
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

  assign phase = phase_q;
  assign step  = step_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomised scoreboard bench for phase_sequencer: two configurations share stimulus,
// a phase/step reference model predicts every cycle and a monitor compares at negedge.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic reset_n, run, ITA, ACK, FROM_D, TO_D;

  logic [11:0] oh_a;
  logic [2:0]  ph_a, st_a;
  logic        stall_a, done_a;
  logic [3:0]  cnt_a;

  logic [6:0]  oh_b;
  logic [2:0]  ph_b, st_b;
  logic        stall_b, done_b;
  logic [7:0]  cnt_b;

  always #5 clk = ~clk;

  phase_sequencer #(.CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .ITA(ITA), .ACK(ACK),
    .FROM_D(FROM_D), .TO_D(TO_D), .state_oh(oh_a), .phase(ph_a), .step(st_a),
    .stall(stall_a), .instr_done(done_a), .inst_count(cnt_a)
  );

  phase_sequencer #(
    .IF_N(1), .FF_N(2), .TF_N(1), .EX_N(1), .IT_N(2), .ACK_WAIT(1'b0), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .ITA(ITA), .ACK(ACK),
    .FROM_D(FROM_D), .TO_D(TO_D), .state_oh(oh_b), .phase(ph_b), .step(st_b),
    .stall(stall_b), .instr_done(done_b), .inst_count(cnt_b)
  );

  typedef struct packed {
    logic [1:0][11:0] oh;
    logic [1:0][2:0]  ph;
    logic [1:0][2:0]  st;
    logic [1:0]       done;
    logic [1:0]       stall;
    logic [1:0][7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  bit   skip_adv = 1'b0;

  // Reference model: phase number 0..4 (IF,FF,TF,EX,IT), step within phase, retire count.
  int unsigned len[2][5] = '{'{2, 3, 2, 2, 3}, '{1, 2, 1, 1, 2}};
  bit          ackw[2]   = '{1'b1, 1'b0};
  int unsigned cw[2]     = '{4, 8};
  int unsigned m_ph[2], m_st[2], m_cnt[2];
  bit          m_done[2];

  function automatic logic [11:0] m_oh(int i);
    int unsigned pos = m_st[i];
    for (int unsigned p = 0; p < m_ph[i]; p++) pos += len[i][p];
    return 12'(1) << pos;
  endfunction

  function automatic bit m_wait(int i);
    return ackw[i] && (m_st[i] == len[i][m_ph[i]] - 1) && (m_ph[i] != 3);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic m_adv(bit r, bit ita, bit ack, bit fd, bit td);
    for (int i = 0; i < 2; i++) begin
      bit ret;
      ret = 1'b0;
      m_done[i] = 1'b0;
      if (r) begin
        if (m_st[i] != len[i][m_ph[i]] - 1) begin
          m_st[i]++;
        end else if (!(m_wait(i) && !ack)) begin
          m_st[i] = 0;
          case (m_ph[i])
            0: m_ph[i] = !fd ? 1 : (!td ? 2 : 3);
            1: m_ph[i] = !td ? 2 : 3;
            2: m_ph[i] = 3;
            3: if (ita) m_ph[i] = 4; else begin m_ph[i] = 0; ret = 1'b1; end
            default: begin m_ph[i] = 0; ret = 1'b1; end
          endcase
        end
      end
      if (ret) begin
        m_done[i] = 1'b1;
        m_cnt[i]  = (m_cnt[i] + 1) % (1 << cw[i]);
      end
    end
  endtask

  function automatic exp_t m_expect();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      x.oh[i]    = m_oh(i);
      x.ph[i]    = 3'(m_ph[i]);
      x.st[i]    = 3'(m_st[i]);
      x.done[i]  = m_done[i];
      x.stall[i] = run && m_wait(i) && !ACK;
      x.cnt[i]   = 8'(m_cnt[i]);
    end
    return x;
  endfunction

  task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=0x%0h expected=0x%0h at %0t", name, i, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_oh"},    0, 32'(oh_a),    32'h1);
    chk({tag, "_phase"}, 0, 32'(ph_a),    32'h0);
    chk({tag, "_step"},  0, 32'(st_a),    32'h0);
    chk({tag, "_done"},  0, 32'(done_a),  32'h0);
    chk({tag, "_cnt"},   0, 32'(cnt_a),   32'h0);
    chk({tag, "_stall"}, 0, 32'(stall_a), 32'h0);
    chk({tag, "_oh"},    1, 32'(oh_b),    32'h1);
    chk({tag, "_phase"}, 1, 32'(ph_b),    32'h0);
    chk({tag, "_cnt"},   1, 32'(cnt_b),   32'h0);
    chk({tag, "_done"},  1, 32'(done_b),  32'h0);
  endtask

  task automatic drive_rand();
    run    = ($urandom_range(0, 9) != 0);
    ACK    = ($urandom_range(0, 9) < 7);
    ITA    = ($urandom_range(0, 3) == 0);
    FROM_D = ($urandom_range(0, 1) == 1);
    TO_D   = ($urandom_range(0, 1) == 1);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("state_oh",   0, 32'(oh_a),    32'(e.oh[0]));
      chk("phase",      0, 32'(ph_a),    32'(e.ph[0]));
      chk("step",       0, 32'(st_a),    32'(e.st[0]));
      chk("instr_done", 0, 32'(done_a),  32'(e.done[0]));
      chk("stall",      0, 32'(stall_a), 32'(e.stall[0]));
      chk("inst_count", 0, 32'(cnt_a),   32'(e.cnt[0][3:0]));
      chk("state_oh",   1, 32'(oh_b),    32'(e.oh[1][6:0]));
      chk("phase",      1, 32'(ph_b),    32'(e.ph[1]));
      chk("step",       1, 32'(st_b),    32'(e.st[1]));
      chk("instr_done", 1, 32'(done_b),  32'(e.done[1]));
      chk("stall",      1, 32'(stall_b), 32'(e.stall[1]));
      chk("inst_count", 1, 32'(cnt_b),   32'(e.cnt[1]));
    end
  end

  initial begin
    reset_n = 1'b0;
    run = 1'b0; ITA = 1'b0; ACK = 1'b0; FROM_D = 1'b0; TO_D = 1'b0;
    m_reset();
    #12;
    check_reset_vals("reset");
    #5;
    reset_n = 1'b1;
    drive_rand();
    sb.push_back(m_expect());
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (skip_adv) begin
        reset_n  = 1'b1;
        skip_adv = 1'b0;
      end else begin
        m_adv(run, ITA, ACK, FROM_D, TO_D);
      end
      if (c == 2000) begin
        // Asynchronous reset between edges must clear outputs with no clock.
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        m_reset();
        skip_adv = 1'b1;
      end
      drive_rand();
      sb.push_back(m_expect());
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drain", 0, 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed-length status counter.
- Generates the instruction-cycle phase/step timing that drives the ISR decoder. Phases are IF (instruction fetch), FF (from-operand fetch), TF (to-operand fetch), EX (execute) and IT (interrupt entry).
- Step count per phase is configurable.
- New over the previous generation: memory-step wait on ACK, global run/stall, operand-phase skipping, and a retired-instruction counter with completion pulse.

Parameters:
- IF_N, 2, number of IF steps (1..8)
- FF_N, 3, number of FF steps (1..8)
- TF_N, 2, number of TF steps (1..8)
- EX_N, 2, number of EX steps (1..8)
- IT_N, 3, number of IT steps (1..8)
- ACK_WAIT, 1, 1 = last step of IF/FF/TF/IT holds until ACK; 0 = ACK ignored
- CNT_W, 16, width of the retired-instruction counter
- TOTAL, IF_N+FF_N+TF_N+EX_N+IT_N, derived width of state_oh (12 at defaults)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  1 = sequencer may advance; 0 = freeze all state
- ITA  in  1  interrupt accept request, sampled at last EX step
- ACK  in  1  memory access acknowledge
- FROM_D  in  1  from-operand is register-direct; skip FF
- TO_D  in  1  to-operand is register-direct; skip TF
- state_oh  out  TOTAL  one-hot step vector, packed LSB-first IF,FF,TF,EX,IT (defaults: IF[1:0] FF[4:2] TF[6:5] EX[8:7] IT[11:9])
- phase  out  3  encoded phase: 0=IF 1=FF 2=TF 3=EX 4=IT
- step  out  3  step index within current phase
- stall  out  1  combinational; run=1 AND current step is an ACK-wait step AND ACK=0
- instr_done  out  1  registered one-cycle pulse on instruction retirement
- inst_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, reset_n=0): phase=IF, step=0, state_oh=1 (bit 0 only), stall=0, instr_done=0, inst_count=0. Takes effect immediately, mid-operation included. First advance is on the first clk edge after reset_n rises.
- Exactly one state_oh bit is high at all times. phase/step and state_oh are consistent, all registered.
- Each clk edge with run=0: no state change; instr_done forced 0 next cycle; inst_count held.
- Each clk edge with run=1:
  - Not on the last step of the phase: step+1.
  - On the last step: advance to the next phase at step 0, subject to the ACK-wait rule below.
- ACK-wait rule: with ACK_WAIT=1, the last step of IF, FF, TF and IT advances only if ACK=1 on that edge; otherwise it holds and stall=1. With ACK_WAIT=0, stall is always 0. ACK is ignored on all other steps.
- Phase transitions (FROM_D/TO_D/ITA are sampled on the advancing edge):
  - IF last → FF if FROM_D=0; else TF if TO_D=0; else EX.
  - FF last → TF if TO_D=0; else EX.
  - TF last → EX.
  - EX last → IT if ITA=1; else IF.
  - IT last → IF.
- Retirement:
  - Occurs on the EX-last→IF transition or the IT-last→IF transition.
  - instr_done=1 during the first cycle of the new IF step 0, 0 otherwise.
  - inst_count increments by 1 on the same edge and wraps from 2^CNT_W-1 to 0.
  - EX-last→IT is not a retirement; the instruction retires when IT completes. One count per instruction.
- Single-step phase (N=1): step 0 is also the last step; the ACK-wait rule applies to it.
- Simultaneous run=0 and ACK=1: the freeze wins.
- Simultaneous ITA and FROM_D/TO_D: independent, since they are sampled at different phases.
- Parameter values outside 1..8 are illegal; the implementation flags them with an elaboration-time error.

Test Plan:
- Defaults; reset, run=1, ACK=1, FROM_D=TO_D=ITA=0 → state_oh 001,002,004,008,010,020,040,080,100, then 001. instr_done=1 at the return to 001; inst_count=1; 9 cycles per instruction.
- FROM_D=1, TO_D=1 → state_oh 001,002,080,100,001; 4 cycles per instruction. FROM_D=0, TO_D=1 → 001,002,004,008,010,080,100,001.
- Hold ACK=0 for 3 cycles while at IF1 (state_oh 002) → stays 002, stall=1 for 3 cycles. Advances to 004 on the edge where ACK=1. stall=0 on non-wait steps even with ACK=0.
- ITA=1 at EX1 → 100,200,400,800. IT2 holds while ACK=0, then returns to 001. inst_count increments once, only on IT2→IF0.
- run=0 at FF1 (008) for 5 cycles → frozen at 008, inst_count unchanged. Then reset_n=0 mid TF0 (020) → immediately state_oh=001, inst_count=0, instr_done=0, without waiting for a clock edge.
- CNT_W=4, FROM_D=TO_D=1 → after 15 instructions inst_count=15; the 16th retirement wraps it to 0 with instr_done=1.
